// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Returns an outstanding vending balance as physical coins when the upstream
// timeout/return timer fires. The balance is latched on accept and paid out
// greedily, largest available denomination first, one coin per hopper
// handshake. Each coin taken by the hopper is reported back so the upstream
// balance logic can drain its total.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous, active-low reset
//   timeout       level-sensitive return request from the timer
//   current_total outstanding balance, sampled when a sequence is accepted
//   coin_avail    per-denomination hopper-not-empty flags
//   coin_ack      hopper has taken the coin offered on return_coin
//   return_coin   one-hot coin offer to the hopper (all-zero = no offer)
//   deduct_valid  one-cycle pulse: deduct_value has been dispensed
//   deduct_value  value of the coin just dispensed
//   busy          high in every state except IDLE
//   done          one-cycle pulse when the return sequence ends
//   residue       amount still owed at done; 0 on full payout
//
// Denomination values must be strictly increasing with index. Only indices
// 0..2 carry a value; NUM_COINS is expected to be 3.
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int          NUM_COINS = 3,
  parameter logic [31:0] COIN_VAL0 = 32'd100,
  parameter logic [31:0] COIN_VAL1 = 32'd500,
  parameter logic [31:0] COIN_VAL2 = 32'd1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 timeout,
  input  logic [31:0]          current_total,
  input  logic [NUM_COINS-1:0] coin_avail,
  input  logic                 coin_ack,
  output logic [NUM_COINS-1:0] return_coin,
  output logic                 deduct_valid,
  output logic [31:0]          deduct_value,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          residue
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_OFFER,
    S_DONE,
    S_WAIT_CLR
  } state_t;

  state_t               state, state_next;
  logic [31:0]          remaining, remaining_next;
  logic [NUM_COINS-1:0] return_coin_next;
  logic                 deduct_valid_next;
  logic [31:0]          deduct_value_next;
  logic                 busy_next;
  logic                 done_next;
  logic [31:0]          residue_next;

  logic                 pick_found;
  logic [NUM_COINS-1:0] pick_onehot;
  logic [31:0]          offer_value;

  function automatic logic [31:0] coin_value(input int idx);
    case (idx)
      0:       coin_value = COIN_VAL0;
      1:       coin_value = COIN_VAL1;
      2:       coin_value = COIN_VAL2;
      default: coin_value = '0;
    endcase
  endfunction

  // Highest usable denomination: scanning upward lets the last hit win.
  // Zero-valued slots are skipped so an oversized NUM_COINS cannot loop forever
  // dispensing nothing.
  always_comb begin
    // NOTE: every variable written here gets a default first; a missed
    // assignment on any path would otherwise infer a latch.
    pick_found  = 1'b0;
    pick_onehot = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (coin_avail[i] && (coin_value(i) != '0) && (coin_value(i) <= remaining)) begin
        pick_found     = 1'b1;
        pick_onehot    = '0;
        pick_onehot[i] = 1'b1;
      end
    end
  end

  // Value of the coin currently on offer, decoded from the one-hot bus so no
  // separate index register is needed.
  always_comb begin
    offer_value = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (return_coin[i]) offer_value = coin_value(i);
    end
  end

  always_comb begin
    state_next        = state;
    remaining_next    = remaining;
    return_coin_next  = return_coin;
    deduct_valid_next = 1'b0;
    deduct_value_next = deduct_value;
    residue_next      = residue;

    case (state)
      S_IDLE: begin
        if (timeout) begin
          remaining_next = current_total;
          residue_next   = '0;
          state_next     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (pick_found) begin
          return_coin_next = pick_onehot;
          state_next       = S_OFFER;
        end else begin
          residue_next = remaining;
          state_next   = S_DONE;
        end
      end
      S_OFFER: begin
        // The offer stands even if availability drops; it is only re-checked
        // in SELECT. Selection guaranteed offer_value <= remaining.
        if (coin_ack && (return_coin != '0)) begin
          remaining_next    = remaining - offer_value;
          deduct_valid_next = 1'b1;
          deduct_value_next = offer_value;
          return_coin_next  = '0;
          state_next        = S_SELECT;
        end
      end
      S_DONE: begin
        state_next = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        // Hold off re-triggering until the timer has dropped its request.
        if (!timeout) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Registered decodes of the next state so busy/done line up with state.
    done_next = (state_next == S_DONE);
    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      remaining    <= '0;
      return_coin  <= '0;
      deduct_valid <= 1'b0;
      deduct_value <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      residue      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before this edge, independent of statement order.
      state        <= state_next;
      remaining    <= remaining_next;
      return_coin  <= return_coin_next;
      deduct_valid <= deduct_valid_next;
      deduct_value <= deduct_value_next;
      busy         <= busy_next;
      done         <= done_next;
      residue      <= residue_next;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
`timescale 1ns/1ps
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        timeout;
  logic [31:0] current_total;
  logic [2:0]  coin_avail;
  logic        coin_ack;
  logic [2:0]  return_coin;
  logic        deduct_valid;
  logic [31:0] deduct_value;
  logic        busy;
  logic        done;
  logic [31:0] residue;

  change_dispenser dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .timeout      (timeout),
    .current_total(current_total),
    .coin_avail   (coin_avail),
    .coin_ack     (coin_ack),
    .return_coin  (return_coin),
    .deduct_valid (deduct_valid),
    .deduct_value (deduct_value),
    .busy         (busy),
    .done         (done),
    .residue      (residue)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Hopper behaviour knobs.
  int ack_delay  = 0;
  bit ack_always = 1'b0;
  int offer_age  = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: with availability fixed for the sequence, repeatedly
  // taking the largest affordable coin equals draining each denomination in
  // turn from the top.
  task automatic expect_seq(input logic [31:0] total, input logic [2:0] avail,
                            output logic [31:0] res);
    int   vals[3] = '{100, 500, 1000};
    int   rem;
    exp_t e;
    rem = int'(total);
    for (int i = 2; i >= 0; i--) begin
      while (avail[i] && vals[i] <= rem) begin
        e.is_done = 1'b0;
        e.value   = 32'(vals[i]);
        exp_q.push_back(e);
        rem -= vals[i];
      end
    end
    e.is_done = 1'b1;
    e.value   = 32'(rem);
    exp_q.push_back(e);
    res = 32'(rem);
  endtask

  // Hopper: acks an offer once it has been visible for more than ack_delay
  // sampling points, or unconditionally when ack_always is set.
  always @(negedge clk) begin
    if (return_coin != '0) offer_age++;
    else                   offer_age = 0;
    coin_ack = ack_always || ((return_coin != '0) && (offer_age > ack_delay));
  end

  // Monitor: pops the scoreboard whenever the DUT reports a coin or done.
  exp_t       mon_e;
  logic [2:0] prev_rc   = '0;
  logic       prev_done = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_rc   = '0;
      prev_done = 1'b0;
    end else begin
      if (deduct_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_deduct: got %0d, expected no event", deduct_value);
        end else begin
          mon_e = exp_q.pop_front();
          check("deduct_kind", {31'b0, mon_e.is_done}, 32'd0);
          check("deduct_value", deduct_value, mon_e.value);
        end
      end
      if (done) begin
        check("done_single", {31'b0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got residue %0d, expected no event", residue);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_kind", {31'b0, mon_e.is_done}, 32'd1);
          check("residue", residue, mon_e.value);
        end
      end
      if (return_coin != '0) begin
        check("offer_onehot", {31'b0, $onehot(return_coin)}, 32'd1);
        if (prev_rc != '0) check("offer_stable", {29'b0, return_coin}, {29'b0, prev_rc});
      end
      prev_rc   = return_coin;
      prev_done = done;
    end
  end

  // Waits for done (bounded), checks the WAIT_CLR hold-off and the return to
  // IDLE. current_total is scrambled after accept to prove it was latched.
  task automatic finish_seq(input logic [31:0] res, output int lat);
    int cyc = 0;
    bit got = 1'b0;
    while (cyc < 300 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) current_total = $urandom;
      if (done) got = 1'b1;
    end
    lat = cyc;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", cyc);
      exp_q.delete();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wait_clr_busy", {31'b0, busy}, 32'd1);
      check("wait_clr_no_offer", {29'b0, return_coin}, 32'd0);
      check("residue_hold", residue, res);
    end
    timeout = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_seq(input logic [31:0] total, input logic [2:0] avail,
                         input int delay, input bit always_ack, output int lat);
    logic [31:0] res;
    @(negedge clk);
    current_total = total;
    coin_avail    = avail;
    ack_delay     = delay;
    ack_always    = always_ack;
    expect_seq(total, avail, res);
    timeout = 1'b1;
    finish_seq(res, lat);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_return_coin"}, {29'b0, return_coin}, 32'd0);
    check({tag, "_deduct_valid"}, {31'b0, deduct_valid}, 32'd0);
    check({tag, "_deduct_value"}, deduct_value, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_residue"}, residue, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          cyc;
    logic [31:0] res;

    reset_n       = 1'b0;
    timeout       = 1'b0;
    current_total = '0;
    coin_avail    = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // 1700 with everything available and ack tied high.
    run_seq(32'd1700, 3'b111, 0, 1'b1, lat);
    // Largest coin missing: two 500s.
    run_seq(32'd1000, 3'b011, 0, 1'b0, lat);
    // Unrepresentable remainder.
    run_seq(32'd250, 3'b111, 0, 1'b0, lat);
    // Slow hopper: each offer waits 5 cycles before ack.
    run_seq(32'd600, 3'b111, 5, 1'b0, lat);

    // Asynchronous reset during OFFER, then restart from the new total.
    @(negedge clk);
    current_total = 32'd1700;
    coin_avail    = 3'b111;
    ack_delay     = 4;
    ack_always    = 1'b0;
    expect_seq(32'd1700, 3'b111, res);
    timeout = 1'b1;
    cyc = 0;
    while (return_coin == '0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("offer_before_reset", {31'b0, (return_coin != '0)}, 32'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    current_total = 32'd600;
    expect_seq(32'd600, 3'b111, res);
    @(negedge clk);
    check_all_zero("midreset_hold");
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    finish_seq(res, lat);

    // Zero balance: done two cycles after timeout is raised, no coins.
    run_seq(32'd0, 3'b111, 0, 1'b0, lat);
    check("zero_done_latency", 32'(lat), 32'd2);

    // Randomized sequences.
    for (int k = 0; k < 10; k++) begin
      run_seq(32'($urandom_range(0, 40) * 50), 3'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), 1'b0, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
